// File: rtl/systolic_sched_pkg.sv
`default_nettype none
// =============================================================================
// systolic_sched_pkg : state encoding, lane widths and drain length    Rev 1.0
// =============================================================================
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int ACT_W   = 4;
  localparam int CODE_W  = 4;
  localparam int PE_UP_W = 8;

  // Cycles for the last operand to ripple from the edge to the far corner PE.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_sched_if.sv
`default_nettype none
// =============================================================================
// systolic_sched_if : command, operand-buffer and PE-edge signals      Rev 1.0
// =============================================================================
interface systolic_sched_if
  import systolic_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int AW    = 4
) ();

  logic                   start;
  logic [AW:0]            cfg_k;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   buf_rd_en;
  logic [AW-1:0]          buf_rd_addr;
  logic [N*ACT_W-1:0]     buf_left_data;
  logic [N*CODE_W-1:0]    buf_up_data;
  logic                   arr_clr;
  logic [N*ACT_W-1:0]     left_bus;
  logic [N*PE_UP_W-1:0]   up_bus;

  modport master (
    input  start, cfg_k, abort, buf_left_data, buf_up_data,
    output busy, done, buf_rd_en, buf_rd_addr, arr_clr, left_bus, up_bus
  );

  modport slave (
    output start, cfg_k, abort, buf_left_data, buf_up_data,
    input  busy, done, buf_rd_en, buf_rd_addr, arr_clr, left_bus, up_bus
  );

endinterface
`default_nettype wire

// File: rtl/systolic_sched_skew_line.sv
`default_nettype none
// =============================================================================
// skew_line : DEPTH-stage data+valid delay line, outputs zero when invalid Rev 1.0
// =============================================================================
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 4
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  input  wire logic         flush_i,
  input  wire logic         valid_i,
  input  wire logic [W-1:0] data_i,
  output logic      [W-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clk_i, rst_ni, flush_i};
      assign data_o      = valid_i ? data_i : '0;
    end else begin : g_pipe
      logic [W-1:0] data_q  [DEPTH];
      logic         valid_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int s = 0; s < DEPTH; s++) begin
            data_q[s]  <= '0;
            valid_q[s] <= 1'b0;
          end
        end else if (flush_i) begin
          for (int s = 0; s < DEPTH; s++) begin
            data_q[s]  <= '0;
            valid_q[s] <= 1'b0;
          end
        end else begin
          data_q[0]  <= data_i;
          valid_q[0] <= valid_i;
          for (int s = 1; s < DEPTH; s++) begin
            data_q[s]  <= data_q[s-1];
            valid_q[s] <= valid_q[s-1];
          end
        end
      end

      assign data_o = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_sched.sv
`default_nettype none
// =============================================================================
// systolic_sched : clear/feed/drain sequencer with diagonal edge skew  Rev 1.0
// =============================================================================
module systolic_sched
  import systolic_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int AW    = 4
) (
  input wire logic         clk_i,
  input wire logic         rst_ni,
  systolic_sched_if.master bus
);

  localparam int             KW         = AW + 1;
  localparam int             DRAIN_LEN  = drain_len(N);
  localparam int             DW         = $clog2(DRAIN_LEN + 1);
  localparam logic [KW-1:0]  KMAX_C     = KW'(K_MAX);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_LEN - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   drain_q;
  logic            rd_valid_q;
  logic            busy, done, rd_en, clr, flush, last_addr;
  logic [N*ACT_W-1:0]   left_w;
  logic [N*PE_UP_W-1:0] up_w;

  assign last_addr = ({1'b0, addr_q} == (k_q - KW'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    clr     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = CLR;
      CLR: begin
        busy = 1'b1;
        clr  = 1'b1;
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (k_q == '0) state_d = DONE;
        else                    state_d = FEED;
      end
      FEED: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (last_addr) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (drain_q == '0) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Depth is captured only on an accepted start so mid-pass cfg_k changes are harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q        <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start)
        k_q <= (bus.cfg_k > KMAX_C) ? KMAX_C : bus.cfg_k;
      addr_q     <= rd_en ? addr_q + 1'b1 : '0;
      rd_valid_q <= rd_en & ~flush;
      if (state_q == FEED)
        drain_q <= DRAIN_LAST;
      else if (state_q == DRAIN && drain_q != '0)
        drain_q <= drain_q - 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [CODE_W-1:0] code;

      skew_line #(.DEPTH(i), .W(ACT_W)) u_row (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .valid_i (rd_valid_q),
        .data_i  (bus.buf_left_data[ACT_W*i +: ACT_W]),
        .data_o  (left_w[ACT_W*i +: ACT_W])
      );

      skew_line #(.DEPTH(i), .W(CODE_W)) u_col (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush),
        .valid_i (rd_valid_q),
        .data_i  (bus.buf_up_data[CODE_W*i +: CODE_W]),
        .data_o  (code)
      );

      assign up_w[PE_UP_W*i +: PE_UP_W] = {{(PE_UP_W-CODE_W){1'b0}}, code};
    end
  endgenerate

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = addr_q;
  assign bus.arr_clr     = clr;
  assign bus.left_bus    = left_w;
  assign bus.up_bus      = up_w;

endmodule
`default_nettype wire

// File: tb/tb_systolic_sched.sv
`default_nettype none
// =============================================================================
// tb_systolic_sched : randomized passes against a cycle-schedule model  Rev 1.0
// =============================================================================
module tb_systolic_sched;
  import systolic_sched_pkg::*;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int AW    = 4;

  typedef struct {int c; int a;} rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_sched_if #(.N(N), .K_MAX(K_MAX), .AW(AW)) bus ();

  systolic_sched #(.N(N), .K_MAX(K_MAX), .AW(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Operand buffers and the expected schedule, keyed by absolute cycle number.
  logic [3:0]       mem_l [K_MAX][N];
  logic [3:0]       mem_u [K_MAX][N];
  bit [N*4-1:0]     exp_left [int];
  bit [N*8-1:0]     exp_up   [int];
  bit               exp_busy [int];
  rd_t              rd_q [$];
  int               clr_q [$];
  int               done_q [$];
  bit [N*4-1:0]     tl, tu;
  rd_t              mon_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, cyc, act, req);
    end
  endtask

  // Buffer returns data one cycle after a read; garbage otherwise so zero-fill is exercised.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.buf_rd_en === 1'b1) begin
        tl[4*i +: 4] = mem_l[bus.buf_rd_addr][i];
        tu[4*i +: 4] = mem_u[bus.buf_rd_addr][i];
      end else begin
        tl[4*i +: 4] = 4'($urandom);
        tu[4*i +: 4] = 4'($urandom);
      end
    end
    bus.buf_left_data <= tl;
    bus.buf_up_data   <= tu;
  end

  function automatic void put_lane(input int t, input int i, input logic [3:0] l, input logic [3:0] u);
    if (!exp_left.exists(t)) exp_left[t] = '0;
    if (!exp_up.exists(t))   exp_up[t]   = '0;
    exp_left[t][4*i +: 4] = l;
    exp_up[t][8*i +: 8]   = {4'b0, u};
  endfunction

  // Start sampled in cycle c; abort_m >= 0 aborts in cycle F+abort_m. Returns last busy cycle.
  function automatic int plan_pass(input int c, input int kcfg, input int abort_m);
    int k, f, e, nrd;
    k = (kcfg > K_MAX) ? K_MAX : kcfg;
    clr_q.push_back(c + 1);
    if (k == 0) begin
      e = c + 2;
      done_q.push_back(e);
    end else begin
      f = c + 2;
      if (abort_m >= 0) begin
        e   = f + abort_m;
        nrd = (abort_m + 1 < k) ? abort_m + 1 : k;
      end else begin
        e   = f + k + 2 * N - 1;
        nrd = k;
        done_q.push_back(e);
      end
      for (int a = 0; a < nrd; a++) begin
        rd_q.push_back('{c: f + a, a: a});
        for (int i = 0; i < N; i++)
          if (f + a + 1 + i <= e) put_lane(f + a + 1 + i, i, mem_l[a][i], mem_u[a][i]);
      end
    end
    for (int t = c + 1; t <= e; t++) exp_busy[t] = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", bus.busy, exp_busy.exists(cyc));
      chk("left_bus", bus.left_bus, exp_left.exists(cyc) ? exp_left[cyc] : '0);
      chk("up_bus", bus.up_bus, exp_up.exists(cyc) ? exp_up[cyc] : '0);
      if (bus.arr_clr !== 1'b0) begin
        if (clr_q.size() == 0) chk("arr_clr_unexpected", bus.arr_clr, 0);
        else chk("arr_clr_cycle", cyc, clr_q.pop_front());
      end
      if (bus.buf_rd_en !== 1'b0) begin
        if (rd_q.size() == 0) chk("rd_en_unexpected", bus.buf_rd_en, 0);
        else begin
          mon_r = rd_q.pop_front();
          chk("rd_cycle", cyc, mon_r.c);
          chk("rd_addr", bus.buf_rd_addr, mon_r.a);
        end
      end
      if (bus.done !== 1'b0) begin
        if (done_q.size() == 0) chk("done_unexpected", bus.done, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (clr_q.size() > 0 && clr_q[0] < cyc)   chk("arr_clr_missed", cyc, clr_q.pop_front());
      if (rd_q.size() > 0 && rd_q[0].c < cyc)   begin mon_r = rd_q.pop_front(); chk("rd_missed", cyc, mon_r.c); end
      if (done_q.size() > 0 && done_q[0] < cyc) chk("done_missed", cyc, done_q.pop_front());
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_done"},   bus.done, 0);
    chk({tag, "_rd_en"},  bus.buf_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.buf_rd_addr, 0);
    chk({tag, "_arr_clr"}, bus.arr_clr, 0);
    chk({tag, "_left"},   bus.left_bus, 0);
    chk({tag, "_up"},     bus.up_bus, 0);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < K_MAX; a++)
      for (int i = 0; i < N; i++) begin
        mem_l[a][i] = 4'($urandom);
        mem_u[a][i] = 4'($urandom);
      end
  endtask

  task automatic run_pass(input int kcfg, input int abort_m, input bit noise, input bit abort_in_done);
    int c, e;
    @(posedge clk); #1;
    c = cyc;
    bus.start = 1'b1;
    bus.cfg_k = 5'(kcfg);
    e = plan_pass(c, kcfg, abort_m);
    @(posedge clk); #1;
    while (cyc <= e) begin
      bus.abort = (abort_m >= 0 && cyc == c + 2 + abort_m) || (abort_in_done && cyc == e);
      bus.start = noise ? 1'($urandom) : 1'b0;
      bus.cfg_k = noise ? 5'($urandom) : bus.cfg_k;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'($urandom);
    @(posedge clk); #1;
    bus.abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int kc, m, c, e1, e2;
    bus.start = 1'b0;
    bus.cfg_k = '0;
    bus.abort = 1'b0;
    fill_mem();
    #3 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_pass(3, -1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) begin
      mem_l[0][i] = 4'(i + 1);
      mem_u[0][i] = 4'(i);
    end
    run_pass(1, -1, 1'b0, 1'b0);

    fill_mem(); run_pass(0, -1, 1'b0, 1'b0);
    fill_mem(); run_pass(20, -1, 1'b0, 1'b0);
    fill_mem(); run_pass(8, 1, 1'b0, 1'b0);
    fill_mem(); run_pass(5, -1, 1'b0, 1'b0);
    fill_mem(); run_pass(2, -1, 1'b0, 1'b1);

    for (int p = 0; p < 12; p++) begin
      fill_mem();
      kc = $urandom_range(0, 20);
      m  = -1;
      if (kc > 0 && $urandom_range(0, 3) == 0)
        m = $urandom_range(0, ((kc > K_MAX) ? K_MAX : kc) + 2 * N - 2);
      run_pass(kc, m, 1'b1, 1'($urandom));
    end

    // Start held high: the IDLE cycle after DONE accepts the next pass.
    fill_mem();
    @(posedge clk); #1;
    c = cyc;
    bus.start = 1'b1;
    bus.cfg_k = 5'd2;
    e1 = plan_pass(c, 2, -1);
    while (cyc < e1 + 1) begin @(posedge clk); #1; end
    e2 = plan_pass(e1 + 1, 2, -1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc <= e2) begin @(posedge clk); #1; end

    // Reset in the middle of DRAIN.
    fill_mem();
    @(posedge clk); #1;
    c = cyc;
    bus.start = 1'b1;
    bus.cfg_k = 5'd2;
    e1 = plan_pass(c, 2, -1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c + 6) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    exp_left.delete(); exp_up.delete(); exp_busy.delete();
    rd_q.delete(); clr_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    fill_mem(); run_pass(4, -1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("clr_q_drained", clr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_sched.md
Name: systolic_sched

Overview:
- Sequencing controller for the N×N systolic array of power-of-two MAC PEs. Each PE takes a 4-bit activation on its left input and a shift code in up_in[3:0], and accumulates activation<<code every clock.
- On start, the block clears the array accumulators, then fetches K operand vectors from the row and column operand buffers.
- It applies the diagonal skew, zero-fills idle edge lanes, waits for the array to drain, then pulses done.
- Sits between the top-level command logic and the PE grid.

Parameters:
N, 4, array dimension (rows = columns = lanes)
K_MAX, 16, maximum accumulation depth
AW, 4, operand buffer address width, clog2(K_MAX)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request a new matrix pass; sampled in IDLE only
cfg_k  in  AW+1  accumulation depth 0..K_MAX; latched on accepted start
abort  in  1  cancel the pass in progress
busy  out  1  high from CLR through DONE
done  out  1  one-cycle pulse when all PE accumulators are final
buf_rd_en  out  1  operand buffer read strobe
buf_rd_addr  out  AW  operand buffer read address
buf_left_data  in  N*4  activations, lane i at [4i+3:4i]; valid 1 cycle after buf_rd_en
buf_up_data  in  N*4  shift codes, lane j at [4j+3:4j]; valid 1 cycle after buf_rd_en
arr_clr  out  1  active-high accumulator clear to the PE grid
left_bus  out  N*4  row-edge activations into PE(i,0)
up_bus  out  N*8  column-edge words into PE(0,j); code in [3:0], [7:4]=0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, buf_rd_en and arr_clr are 0. buf_rd_addr=0. left_bus, up_bus and all skew registers are 0.
- States: IDLE, CLR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 latches k=cfg_k and moves to CLR.
  - cfg_k>K_MAX is clamped to K_MAX.
- CLR: one cycle with arr_clr=1.
  - Next state is FEED if k>0.
  - Next state is DONE if k=0; no reads are issued.
- FEED: exactly k cycles.
  - buf_rd_en=1; buf_rd_addr counts 0..k-1.
  - Exits to DRAIN after the address k-1 cycle.
- DRAIN: exactly 2N-1 cycles, counted down with a drain counter. Then go to DONE.
- DONE: one cycle with done=1, then IDLE.
- busy=1 in CLR, FEED, DRAIN and DONE.
- Timing, with the FEED first cycle as F:
  - Data for address a is on buf_*_data at cycle F+a+1.
  - Row lane i shows it on left_bus at F+a+1+i; column lane j shows it on up_bus at F+a+1+j.
  - Lane 0 is the buffer data gated by a 1-cycle-delayed rd_en valid bit.
  - Lane i>0 passes through i additional registers carrying data and valid together.
  - Corner PE(N-1,N-1) makes its final update at F+k+2N-2, and done is asserted at F+k+2N-1.
- Zero-fill: any lane whose valid bit is 0 drives 0. The PE then adds 0<<0=0, so idle cycles never corrupt accumulators.
- start in any non-IDLE state is ignored; no queuing.
- abort=1 in CLR, FEED or DRAIN:
  - Next state IDLE; all skew valid bits and edge lanes clear on the next edge.
  - buf_rd_en drops, and done is not pulsed.
- abort in IDLE or DONE is ignored; DONE still pulses.
- abort and start in the same IDLE cycle: start wins.
- Reset mid-pass returns to IDLE immediately. arr_clr is not asserted by reset; the PE grid has its own reset.
- The controller never inspects accumulator overflow; 8-bit wrap in the PEs is by design.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=0, CLR=1, FEED=2, DRAIN=3, DONE=4);
  - the lane width constants ACT_W=4, CODE_W=4, PE_UP_W=8;
  - the function drain_len(N)=2N-1.
- One sub-module: skew_line. Parameters are DEPTH and W; it is a shift register with a valid bit and a zero-on-invalid output.
- It is instantiated 2N times (N row lanes, N column lanes), each with DEPTH equal to its lane index.

Test Plan:
- N=4, cfg_k=3, start at cycle 0:
  - arr_clr high at cycle 1.
  - buf_rd_en at cycles 2–4 with addr 0,1,2.
  - DRAIN at cycles 5–11; done at cycle 12; busy high at cycles 1–12.
- Skew check, N=4, k=1, buf_left_data lane values 1,2,3,4 and codes 0,1,2,3:
  - left_bus lane i=(i+1) appears only at cycle 3+i, and is 0 otherwise.
  - up_bus lane j={4'b0,j} appears at cycle 3+j.
  - With the PE grid attached, PE(3,3) mat_out=4<<3=32 at done.
- cfg_k=0 → arr_clr at cycle 1, done at cycle 2, buf_rd_en never asserted.
- cfg_k=20 with K_MAX=16 → exactly 16 reads (addr 0..15), then done 7 cycles after the last read plus 1.
- abort at the second FEED cycle (k=8) → IDLE next cycle, no done, all edge lanes 0 within 1 cycle. A following start then runs normally.
- start held high throughout → a new pass begins the cycle after DONE. Mid-pass start pulses are ignored, and reset=0 during DRAIN drives all outputs to 0 asynchronously.
